// File: rtl/core_obi_bridge.sv
// core_obi_bridge: registered one-entry request slot between the CVE2 data port and an OBI manager port,
// with an outstanding-transaction limit, in-order response passthrough, busy and sticky protocol-error flags.
module core_obi_bridge #(
  parameter int          MaxOutstanding = 2,
  parameter logic [31:0] ErrRdata       = 32'hBADCAB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_addr_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o,
  output logic        proto_err_o
);
  localparam int CW = $clog2(MaxOutstanding + 1);
  logic          slot_full;
  logic [CW-1:0] pend;
  logic          bus_fire, resp;
  logic [CW:0]   inflight, left;
  assign bus_fire = obi_req_o & obi_gnt_i;
  assign resp     = obi_rvalid_i & (pend != '0);
  assign inflight = (CW+1)'(slot_full) + (CW+1)'(pend);
  // a response retiring this cycle frees its credit for a same-cycle accept
  assign left       = inflight - (CW+1)'(resp);
  assign core_gnt_o = core_req_i & (~slot_full | bus_fire) & (left < (CW+1)'(MaxOutstanding));
  assign obi_req_o     = slot_full;
  assign core_rvalid_o = resp;
  assign core_err_o    = resp & obi_err_i;
  assign core_rdata_o  = obi_err_i ? ErrRdata : obi_rdata_i;
  assign busy_o        = slot_full | (pend != '0);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_full   <= 1'b0;
      pend        <= '0;
      proto_err_o <= 1'b0;
      obi_we_o    <= 1'b0;
      obi_be_o    <= '0;
      obi_addr_o  <= '0;
      obi_wdata_o <= '0;
    end else begin
      pend        <= pend + CW'(bus_fire) - CW'(resp);
      proto_err_o <= proto_err_o | (obi_rvalid_i & (pend == '0));
      if (core_gnt_o) begin
        slot_full   <= 1'b1;
        obi_we_o    <= core_we_i;
        obi_be_o    <= core_be_i;
        obi_addr_o  <= core_addr_i;
        obi_wdata_o <= core_wdata_i;
      end else if (bus_fire) begin
        slot_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_core_obi_bridge.sv
// tb_core_obi_bridge: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_core_obi_bridge;
  localparam int          MAX = 2;
  localparam logic [31:0] ERR = 32'hBADCAB1E;
  logic        clk_i, rst_ni;
  logic        core_req_i, core_gnt_o, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        obi_req_o, obi_gnt_i, obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_addr_o, obi_wdata_o;
  logic        obi_rvalid_i, obi_err_i;
  logic [31:0] obi_rdata_i;
  logic        busy_o, proto_err_o;
  int checks = 0;
  int errors = 0;

  core_obi_bridge #(.MaxOutstanding(MAX), .ErrRdata(ERR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
    .obi_addr_o(obi_addr_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic req; logic we; logic [31:0] addr; logic gnt; logic rv; logic err; logic [31:0] rdata;
    logic e_gnt; logic e_req; logic [31:0] e_addr; logic e_rv; logic e_err; logic [31:0] e_rdata;
    logic e_busy; logic e_perr;
  } vec_t;

  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_err_i = 0; obi_rdata_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // enters and leaves on a falling edge; checks reset state and gnt-follows-req
  task automatic do_reset();
    rst_ni = 0;
    idle_in();
    core_req_i = 1;
    #1;
    chk("rst_gnt_follows_req1", core_gnt_o, 1);
    chk("rst_obi_req", obi_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_proto", proto_err_o, 0);
    chk("rst_obi_addr", obi_addr_o, 0);
    core_req_i = 0;
    #1;
    chk("rst_gnt_follows_req0", core_gnt_o, 0);
    step();
    rst_ni = 1;
  endtask

  vec_t vt[10];
  txn_t slotq[$];
  txn_t t;
  int pend, acc;
  bit perr, fire, resp, egnt;

  initial begin
    rst_ni = 0;
    idle_in();
    @(negedge clk_i);
    do_reset();
    //          req we addr          gnt rv err rdata          e_gnt e_req e_addr       e_rv e_err e_rdata      busy perr
    vt[0] = '{1'b1,1'b0,32'h10000004,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[1] = '{1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h10000004, 1'b0,1'b0,32'h0,        1'b1,1'b0};
    vt[2] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,1'b0,32'hCAFE0001, 1'b0,1'b0,32'h0,        1'b1,1'b0,32'hCAFE0001, 1'b1,1'b0};
    vt[3] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[4] = '{1'b1,1'b0,32'h20000000,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[5] = '{1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h20000000, 1'b0,1'b0,32'h0,        1'b1,1'b0};
    vt[6] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,1'b1,32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b1,ERR,          1'b1,1'b0};
    vt[7] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[8] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,1'b0,32'h55,       1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0};
    vt[9] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1};
    for (int i = 0; i < 10; i++) begin
      core_req_i = vt[i].req; core_we_i = vt[i].we; core_addr_i = vt[i].addr;
      obi_gnt_i = vt[i].gnt; obi_rvalid_i = vt[i].rv; obi_err_i = vt[i].err; obi_rdata_i = vt[i].rdata;
      #1;
      chk($sformatf("v%0d_core_gnt", i), core_gnt_o, vt[i].e_gnt);
      chk($sformatf("v%0d_obi_req", i), obi_req_o, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("v%0d_obi_addr", i), obi_addr_o, vt[i].e_addr);
      chk($sformatf("v%0d_rvalid", i), core_rvalid_o, vt[i].e_rv);
      chk($sformatf("v%0d_err", i), core_err_o, vt[i].e_err);
      if (vt[i].e_rv) chk($sformatf("v%0d_rdata", i), core_rdata_o, vt[i].e_rdata);
      chk($sformatf("v%0d_busy", i), busy_o, vt[i].e_busy);
      chk($sformatf("v%0d_proto", i), proto_err_o, vt[i].e_perr);
      step();
    end
    idle_in();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("spur_proto_hold", proto_err_o, 1);
      chk("spur_busy", busy_o, 0);
      step();
    end

    // grant stall: payload held while the bus withholds gnt, second request refused
    do_reset();
    core_req_i = 1; core_we_i = 1; core_be_i = 4'b0011; core_addr_i = 32'h30000008; core_wdata_i = 32'h12345678;
    #1;
    chk("stall_first_gnt", core_gnt_o, 1);
    step();
    core_we_i = 0; core_be_i = 4'hF; core_addr_i = 32'h40000000; core_wdata_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_obi_req", obi_req_o, 1);
      chk("stall_we", obi_we_o, 1);
      chk("stall_be", obi_be_o, 4'b0011);
      chk("stall_addr", obi_addr_o, 32'h30000008);
      chk("stall_wdata", obi_wdata_o, 32'h12345678);
      chk("stall_core_gnt", core_gnt_o, 0);
      step();
    end
    obi_gnt_i = 1;
    #1;
    chk("stall_reload_gnt", core_gnt_o, 1);
    step();
    core_req_i = 0;
    #1;
    chk("stall_second_addr", obi_addr_o, 32'h40000000);
    chk("stall_second_we", obi_we_o, 0);
    step();
    obi_gnt_i = 0; obi_rvalid_i = 1;
    #1;
    chk("stall_rsp1", core_rvalid_o, 1);
    step();
    #1;
    chk("stall_rsp2", core_rvalid_o, 1);
    step();
    idle_in();
    #1;
    chk("stall_idle_busy", busy_o, 0);

    // back-to-back: two accepts then stall until a response frees a credit
    do_reset();
    core_req_i = 1; obi_gnt_i = 1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      core_addr_i = 32'h100 + 32'(i);
      #1;
      if (core_gnt_o) acc++;
      step();
    end
    chk("b2b_accepts", 32'(acc), 2);
    obi_rvalid_i = 1;
    #1;
    chk("b2b_rsp", core_rvalid_o, 1);
    chk("b2b_gnt_with_rsp", core_gnt_o, 1);
    step();

    // reset mid-flight: slot full plus one pending, dropped asynchronously
    do_reset();
    core_req_i = 1; core_addr_i = 32'hA0;
    step();
    obi_gnt_i = 1; core_addr_i = 32'hB0;
    step();
    idle_in();
    #1;
    chk("mid_obi_req_pre", obi_req_o, 1);
    chk("mid_busy_pre", busy_o, 1);
    rst_ni = 0;
    #1;
    chk("mid_obi_req_async", obi_req_o, 0);
    chk("mid_busy_async", busy_o, 0);
    step();
    rst_ni = 1;
    core_req_i = 1; core_addr_i = 32'hC0;
    #1;
    chk("mid_after_gnt", core_gnt_o, 1);
    step();
    core_req_i = 0; obi_gnt_i = 1;
    #1;
    chk("mid_after_addr", obi_addr_o, 32'hC0);
    step();
    obi_gnt_i = 0; obi_rvalid_i = 1; obi_rdata_i = 32'h600DF00D;
    #1;
    chk("mid_after_rdata", core_rdata_o, 32'h600DF00D);
    chk("mid_after_rvalid", core_rvalid_o, 1);
    step();
    idle_in();
    #1;
    chk("mid_after_busy", busy_o, 0);

    // randomized run against a queue/credit model
    do_reset();
    slotq.delete();
    pend = 0; perr = 0;
    for (int c = 0; c < 400; c++) begin
      core_req_i = $urandom_range(0, 3) != 0;
      core_we_i = 1'($urandom);
      core_be_i = 4'($urandom);
      core_addr_i = $urandom;
      core_wdata_i = $urandom;
      obi_gnt_i = $urandom_range(0, 2) != 0;
      obi_rvalid_i = pend > 0 ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      obi_err_i = $urandom_range(0, 5) == 0;
      obi_rdata_i = $urandom;
      fire = slotq.size() != 0 && obi_gnt_i;
      resp = obi_rvalid_i && pend > 0;
      egnt = core_req_i && (slotq.size() == 0 || fire) && (slotq.size() + pend - int'(resp) < MAX);
      #1;
      chk("rnd_core_gnt", core_gnt_o, egnt);
      chk("rnd_obi_req", obi_req_o, slotq.size() != 0);
      if (slotq.size() != 0) begin
        chk("rnd_obi_we", obi_we_o, slotq[0].we);
        chk("rnd_obi_be", obi_be_o, slotq[0].be);
        chk("rnd_obi_addr", obi_addr_o, slotq[0].addr);
        chk("rnd_obi_wdata", obi_wdata_o, slotq[0].wdata);
      end
      chk("rnd_rvalid", core_rvalid_o, resp);
      chk("rnd_err", core_err_o, resp && obi_err_i);
      if (resp) chk("rnd_rdata", core_rdata_o, obi_err_i ? ERR : obi_rdata_i);
      chk("rnd_busy", busy_o, slotq.size() != 0 || pend > 0);
      chk("rnd_proto", proto_err_o, perr);
      if (obi_rvalid_i && pend == 0) perr = 1;
      if (fire) void'(slotq.pop_front());
      pend = pend + int'(fire) - int'(resp);
      if (egnt) begin
        t.we = core_we_i; t.be = core_be_i; t.addr = core_addr_i; t.wdata = core_wdata_i;
        slotq.push_back(t);
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_obi_bridge.md
Name: core_obi_bridge

Overview:
- Sits directly downstream of the CVE2 core's data port, between the core's req/gnt/rvalid interface and the SoC OBI crossbar manager port.
- Registers the request path (one-entry request slot) to cut the combinational core-to-crossbar path.
- Limits in-flight transactions to MaxOutstanding and passes in-order responses back to the core.
- Drives a busy indication for core clock gating and idle detection, plus a sticky protocol-error flag.

Parameters:
- MaxOutstanding, 2: max transactions accepted from core and not yet responded (slot + granted-pending); legal range 1..7.
- ErrRdata, 32'hBADCAB1E: rdata returned to core on a bus error response.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core request valid
- core_gnt_o  out  1  request accepted this cycle
- core_we_i  in  1  write enable
- core_be_i  in  4  byte enables
- core_addr_i  in  32  byte address
- core_wdata_i  in  32  write data
- core_rvalid_o  out  1  response valid
- core_rdata_o  out  32  read data
- core_err_o  out  1  response error
- obi_req_o  out  1  bus request
- obi_gnt_i  in  1  bus grant
- obi_we_o  out  1  write enable
- obi_be_o  out  4  byte enables
- obi_addr_o  out  32  address
- obi_wdata_o  out  32  write data
- obi_rvalid_i  in  1  bus response valid
- obi_rdata_i  in  32  bus read data
- obi_err_i  in  1  bus error
- busy_o  out  1  slot full or any transaction outstanding
- proto_err_o  out  1  sticky: rvalid received with nothing outstanding

Behaviour:
- Reset state:
  - slot empty, obi_req_o=0, slot payload=0, outstanding count=0, proto_err_o=0.
  - All other outputs are combinational from these and the inputs; at reset core_gnt_o follows core_req_i (limit not reached).
- Counters and terms:
  - inflight = slot_full + pend.
  - pend counts transactions granted on the bus and awaiting rvalid; width $clog2(MaxOutstanding+1).
  - bus_fire = obi_req_o & obi_gnt_i.
  - resp = obi_rvalid_i & (pend != 0).
- Accept:
  - core_gnt_o = core_req_i & (!slot_full | bus_fire) & (inflight - resp < MaxOutstanding).
  - The response term lets a retiring transaction free a credit in the same cycle.
- On core_gnt_o:
  - Capture we/be/addr/wdata into the slot; slot_full=1 next cycle.
  - Request latency is 1 cycle: core grant in cycle N gives obi_req_o=1 in N+1.
- Slot hold:
  - obi_req_o = slot_full.
  - Payload is held stable while obi_req_o=1 and obi_gnt_i=0 (OBI stability rule).
- On bus_fire without a new accept: slot_full clears next cycle.
- bus_fire and core_gnt_o in the same cycle: slot reloads back-to-back with no bubble.
- pend update, next value = pend + bus_fire - resp:
  - Simultaneous increment and decrement nets to zero change.
  - pend never exceeds MaxOutstanding.
- Response path (0-cycle, combinational):
  - core_rvalid_o = resp.
  - core_err_o = resp & obi_err_i.
  - core_rdata_o = obi_err_i ? ErrRdata : obi_rdata_i.
  - Responses return in order; the bridge does no reordering.
- Spurious response (obi_rvalid_i=1 while pend==0):
  - Not forwarded: core_rvalid_o=0.
  - pend stays 0.
  - proto_err_o sets and stays set until reset.
- busy_o = slot_full | (pend != 0); it is registered state only, with no combinational path from the request inputs.
- Async reset mid-transaction: all state drops immediately. The crossbar is reset in the same domain, so no drain is performed.

Test Plan:
- Single read:
  - Stimulus: core_req addr=0x1000_0004 in cycle 0, obi_gnt=1 in cycle 1, obi_rvalid with rdata=0xCAFE0001 in cycle 2.
  - Required: core_gnt cycle 0, obi_req+addr cycle 1, core_rvalid+rdata cycle 2, busy_o low from cycle 3.
- Grant stall:
  - Stimulus: write be=4'b0011 wdata=0x1234_5678, obi_gnt held 0 for 5 cycles.
  - Required: obi_* payload constant across all 5 cycles, and core_gnt_o=0 for the second queued core request.
- Back-to-back with MaxOutstanding=2:
  - Stimulus: continuous core_req and obi_gnt, rvalid delayed by 3 cycles.
  - Required: exactly 2 accepted before stall; a new accept is possible in the same cycle as an rvalid.
- Bus error:
  - Stimulus: obi_rvalid=1 with obi_err=1 and rdata=0x0.
  - Required: core_err_o=1 and core_rdata_o=0xBADCAB1E.
- Spurious response:
  - Stimulus: obi_rvalid=1 when idle.
  - Required: core_rvalid_o=0, proto_err_o=1 and held for 10+ cycles, pend stays 0.
- Reset mid-flight:
  - Stimulus: assert rst_ni=0 with slot full and pend=1.
  - Required: obi_req_o=0 and busy_o=0 immediately (asynchronously); after release the next request completes normally.
